// File: rtl/coin_accumulator.sv
// Coin accumulator: validates coins, tracks credit against the selected product price,
// deducts on purchase and hands any change or refund to the dispenser via req/ack.
module coin_accumulator #(
  parameter int CREDIT_W   = 8,
  parameter int CREDIT_MAX = 50,
  parameter int COIN1_VAL  = 1,
  parameter int COIN2_VAL  = 5,
  parameter int COIN3_VAL  = 10,
  parameter int PRICE0     = 10,
  parameter int PRICE1     = 15,
  parameter int PRICE2     = 20,
  parameter int PRICE3     = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                accept_en,
  input  logic [1:0]          product_sell,
  input  logic                purchase,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                enough_money,
  output logic                coin_reject,
  output logic                purchase_err,
  output logic                change_req,
  output logic [CREDIT_W-1:0] change_amount
);

  typedef enum logic {ST_ACCEPT = 1'b0, ST_REFUND = 1'b1} state_t;

  localparam logic [CREDIT_W:0] CREDIT_MAX_W = (CREDIT_W+1)'(CREDIT_MAX);

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_amount_q;
  logic                change_req_q;
  logic                coin_reject_q;
  logic                purchase_err_q;

  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] price_sel;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] remainder;
  logic                coin_ok;
  logic                price_ok;

  always_comb begin
    coin_value = '0;
    case (coin_code)
      2'b01:   coin_value = CREDIT_W'(COIN1_VAL);
      2'b10:   coin_value = CREDIT_W'(COIN2_VAL);
      2'b11:   coin_value = CREDIT_W'(COIN3_VAL);
      default: coin_value = '0;
    endcase
  end

  always_comb begin
    price_sel = CREDIT_W'(PRICE0);
    case (product_sell)
      2'b00:   price_sel = CREDIT_W'(PRICE0);
      2'b01:   price_sel = CREDIT_W'(PRICE1);
      2'b10:   price_sel = CREDIT_W'(PRICE2);
      default: price_sel = CREDIT_W'(PRICE3);
    endcase
  end

  // One extra bit on the add so a coin near the top of the range cannot wrap past the limit check.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok   = accept_en && (coin_code != 2'b00) && (coin_sum <= CREDIT_MAX_W);
  assign price_ok  = credit_q >= price_sel;
  assign remainder = credit_q - price_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_ACCEPT;
      credit_q        <= '0;
      change_amount_q <= '0;
      change_req_q    <= 1'b0;
      coin_reject_q   <= 1'b0;
      purchase_err_q  <= 1'b0;
    end else begin
      coin_reject_q  <= 1'b0;
      purchase_err_q <= 1'b0;
      if (state_q == ST_ACCEPT) begin
        if (cancel) begin
          if (credit_q != '0) begin
            change_amount_q <= credit_q;
            change_req_q    <= 1'b1;
            state_q         <= ST_REFUND;
          end
        end else if (purchase) begin
          if (price_ok) begin
            credit_q <= remainder;
            if (remainder != '0) begin
              change_amount_q <= remainder;
              change_req_q    <= 1'b1;
              state_q         <= ST_REFUND;
            end
          end else begin
            purchase_err_q <= 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) credit_q <= coin_sum[CREDIT_W-1:0];
          else         coin_reject_q <= 1'b1;
        end
        // A coin arriving alongside cancel or purchase is never banked.
        if (coin_valid && (cancel || purchase)) coin_reject_q <= 1'b1;
      end else begin
        if (coin_valid) coin_reject_q  <= 1'b1;
        if (purchase)   purchase_err_q <= 1'b1;
        if (change_ack) begin
          credit_q        <= '0;
          change_amount_q <= '0;
          change_req_q    <= 1'b0;
          state_q         <= ST_ACCEPT;
        end
      end
    end
  end

  assign credit        = credit_q;
  assign change_amount = change_amount_q;
  assign change_req    = change_req_q;
  assign coin_reject   = coin_reject_q;
  assign purchase_err  = purchase_err_q;
  assign enough_money  = (state_q == ST_ACCEPT) && price_ok;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: directed scenarios with literal checks, then random traffic
// compared every cycle against a plain-integer model of credit and pending payout.
module tb_coin_accumulator;

  localparam int CREDIT_MAX = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       accept_en = 1'b1;
  logic [1:0] product_sell = 2'b00;
  logic       purchase = 1'b0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [7:0] credit;
  logic       enough_money;
  logic       coin_reject;
  logic       purchase_err;
  logic       change_req;
  logic [7:0] change_amount;

  coin_accumulator dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
    .accept_en(accept_en), .product_sell(product_sell), .purchase(purchase),
    .cancel(cancel), .change_ack(change_ack), .credit(credit),
    .enough_money(enough_money), .coin_reject(coin_reject), .purchase_err(purchase_err),
    .change_req(change_req), .change_amount(change_amount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  bit cmp_en = 1'b0;

  int price_tab[4] = '{10, 15, 20, 25};
  int coin_tab[4]  = '{0, 1, 5, 10};

  // Model: credit as an integer, a pending payout amount, and the two pulses.
  int m_credit = 0;
  int m_payout = 0;
  bit m_pending = 1'b0;
  bit m_rej = 1'b0;
  bit m_perr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle_no, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_credit = 0; m_payout = 0; m_pending = 1'b0; m_rej = 1'b0; m_perr = 1'b0;
    end else begin
      cycle_no++;
      m_rej = 1'b0;
      m_perr = 1'b0;
      if (m_pending) begin
        m_rej  = coin_valid;
        m_perr = purchase;
        if (change_ack) begin
          m_credit = 0; m_payout = 0; m_pending = 1'b0;
        end
      end else begin
        if (cancel) begin
          if (m_credit > 0) begin
            m_payout = m_credit; m_pending = 1'b1;
          end
        end else if (purchase) begin
          if (m_credit >= price_tab[product_sell]) begin
            m_credit = m_credit - price_tab[product_sell];
            if (m_credit > 0) begin
              m_payout = m_credit; m_pending = 1'b1;
            end
          end else begin
            m_perr = 1'b1;
          end
        end
        if (coin_valid) begin
          if (cancel || purchase || !accept_en || coin_code == 2'b00 ||
              m_credit + coin_tab[coin_code] > CREDIT_MAX)
            m_rej = 1'b1;
          else
            m_credit = m_credit + coin_tab[coin_code];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("credit", int'(credit), m_credit);
      chk("credit_bound", int'(credit <= 8'(CREDIT_MAX)), 1);
      chk("change_req", int'(change_req), int'(m_pending));
      chk("change_amount", int'(change_amount), m_payout);
      chk("coin_reject", int'(coin_reject), int'(m_rej));
      chk("purchase_err", int'(purchase_err), int'(m_perr));
      chk("enough_money", int'(enough_money),
          int'(!m_pending && m_credit >= price_tab[product_sell]));
    end
  end

  // One clock with the given strobes; returns 2 ns after the edge.
  task automatic cyc(input bit cv, input logic [1:0] cc, input bit pu, input bit ca, input bit ack);
    coin_valid = cv; coin_code = cc; purchase = pu; cancel = ca; change_ack = ack;
    @(posedge clk);
    #2;
    $display("cyc %0d coin=%0b/%0d pur=%0b can=%0b ack=%0b -> credit=%0d req=%0b amt=%0d rej=%0b perr=%0b",
             cycle_no, cv, cc, pu, ca, ack, credit, change_req, change_amount, coin_reject, purchase_err);
  endtask

  task automatic coin(input logic [1:0] cc);
    cyc(1'b1, cc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_credit", int'(credit), 0);
    chk("rst_change_req", int'(change_req), 0);
    chk("rst_change_amount", int'(change_amount), 0);
    chk("rst_pulses", int'({coin_reject, purchase_err}), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #2;

    // Scenario 1: coins 10 then 5 with product 1 (price 15).
    accept_en = 1'b1; product_sell = 2'b01;
    coin(2'b11);
    chk("s1_credit_a", int'(credit), 10);
    chk("s1_enough_a", int'(enough_money), 0);
    coin(2'b10);
    chk("s1_credit_b", int'(credit), 15);
    chk("s1_enough_b", int'(enough_money), 1);

    // Scenario 2: 20 credit, buy product 0, change of 10 acked after 3 cycles.
    coin(2'b10);
    product_sell = 2'b00;
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("s2_credit", int'(credit), 10);
    chk("s2_req", int'(change_req), 1);
    chk("s2_amount", int'(change_amount), 10);
    idle(); idle(); idle();
    chk("s2_req_held", int'(change_req), 1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("s2_credit_ack", int'(credit), 0);
    chk("s2_req_ack", int'(change_req), 0);

    // Scenario 3: cancel 15, coin during refund is rejected.
    coin(2'b11); coin(2'b10);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("s3_amount", int'(change_amount), 15);
    coin(2'b01);
    chk("s3_reject", int'(coin_reject), 1);
    chk("s3_amount_stable", int'(change_amount), 15);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("s3_credit_ack", int'(credit), 0);

    // Scenario 4: credit ceiling, invalid code, closed window.
    coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b10);
    chk("s4_credit45", int'(credit), 45);
    coin(2'b11);
    chk("s4_over_reject", int'(coin_reject), 1);
    chk("s4_credit_kept", int'(credit), 45);
    coin(2'b10);
    chk("s4_credit50", int'(credit), 50);
    coin(2'b00);
    chk("s4_code00_reject", int'(coin_reject), 1);
    accept_en = 1'b0;
    coin(2'b01);
    chk("s4_closed_reject", int'(coin_reject), 1);
    chk("s4_credit_still50", int'(credit), 50);
    accept_en = 1'b1;
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Scenario 5: same-cycle priority and purchase edge cases.
    coin(2'b11); coin(2'b01); coin(2'b01);
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("s5_refund12", int'(change_amount), 12);
    chk("s5_credit12", int'(credit), 12);
    chk("s5_reject", int'(coin_reject), 1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    coin(2'b10); coin(2'b01); coin(2'b01); coin(2'b01);
    product_sell = 2'b00;
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("s5_perr", int'(purchase_err), 1);
    chk("s5_credit8", int'(credit), 8);
    coin(2'b01); coin(2'b01);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("s5_exact_credit", int'(credit), 0);
    chk("s5_exact_noreq", int'(change_req), 0);

    // Scenario 6: asynchronous reset in the middle of a refund.
    coin(2'b11);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("s6_amount10", int'(change_amount), 10);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_req", int'(change_req), 0);
    chk("s6_rst_credit", int'(credit), 0);
    chk("s6_rst_amount", int'(change_amount), 0);
    coin_valid = 1'b0; cancel = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    coin(2'b10);
    chk("s6_credit5", int'(credit), 5);

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      accept_en    = ($urandom_range(7) != 0);
      product_sell = 2'($urandom_range(3));
      cyc($urandom_range(1) == 1, 2'($urandom_range(3)), $urandom_range(7) == 0,
          $urandom_range(15) == 0, $urandom_range(2) == 0);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Front-end money stage directly upstream of the vending FSM controller.
- Validates coin pulses, accumulates credit, and compares it against the price of the currently selected product to drive `enough_money`.
- On a purchase it deducts the price; on cancel it refunds the full credit.
- All change/refund amounts go to the change dispenser through a req/ack handshake.

Parameters:
- CREDIT_W, 8, width of credit and change_amount
- CREDIT_MAX, 50, maximum credit held; any coin pushing credit above this is rejected
- COIN1_VAL, 1, value of coin_code 2'b01
- COIN2_VAL, 5, value of coin_code 2'b10
- COIN3_VAL, 10, value of coin_code 2'b11
- PRICE0, 10, price of product_sell 2'b00
- PRICE1, 15, price of product_sell 2'b01
- PRICE2, 20, price of product_sell 2'b10
- PRICE3, 25, price of product_sell 2'b11

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle strobe, coin present on coin_code
- coin_code  in  2  denomination; 2'b00 is invalid
- accept_en  in  1  coin acceptance window, driven from the FSM WAIT_COIN phase
- product_sell  in  2  selected product index
- purchase  in  1  one-cycle strobe: deduct price of product_sell
- cancel  in  1  one-cycle strobe: refund all credit
- change_ack  in  1  change dispenser has paid change_amount
- credit  out  CREDIT_W  current credit
- enough_money  out  1  credit sufficient for selected product
- coin_reject  out  1  one-cycle pulse, coin returned to user
- purchase_err  out  1  one-cycle pulse, purchase refused
- change_req  out  1  change payout request, level
- change_amount  out  CREDIT_W  amount to pay; stable while change_req=1

Behaviour:
- Reset (async assert, sync release): state=ACCEPT; credit=0, change_amount=0; change_req=0, coin_reject=0, purchase_err=0.
  - Reset mid-REFUND drops change_req immediately and discards credit.
- States:
  - ACCEPT: normal operation.
  - REFUND: payout pending.
- enough_money = (state==ACCEPT) && (credit >= PRICE[product_sell]).
  - Combinational from registered credit and the product_sell input.
  - Not registered.
- ACCEPT, per cycle, priority cancel > purchase > coin:
  - cancel:
    - credit>0: change_amount<=credit, change_req<=1, go REFUND.
    - credit==0: no action.
  - purchase:
    - credit >= price: credit <= credit-price.
      - Remainder >0: change_amount<=remainder, change_req<=1, go REFUND.
      - Remainder ==0: stay ACCEPT, no change_req.
    - credit < price: purchase_err=1 for one cycle, credit unchanged.
  - coin_valid, with accept_en=1, valid code, and credit+value <= CREDIT_MAX: credit<=credit+value.
  - coin_valid otherwise (accept_en=0, code 00, would exceed CREDIT_MAX, or same cycle as cancel/purchase): coin_reject=1 for one cycle, credit unchanged.
- REFUND:
  - change_req held at 1 and change_amount stable until change_ack is sampled high.
  - On ack: credit<=0, change_amount<=0, change_req<=0, go ACCEPT. The block is ready for coins in the cycle after.
  - coin_valid → coin_reject.
  - purchase → purchase_err.
  - cancel → ignored.
  - change_ack while in ACCEPT → ignored.
- Latency: a strobe sampled at edge N is reflected on credit, change_req and the pulse outputs after edge N.
- Arithmetic:
  - The add is computed at CREDIT_W+1 bits, so the overflow check never wraps.
  - Subtract only occurs when credit >= price, so it never underflows.
- Credit always satisfies 0 <= credit <= CREDIT_MAX. Assert this in the bench.

Test Plan:
1. accept_en=1, product_sell=01, coins 11 then 10 → credit 10, then 15; enough_money rises the cycle after the second coin; no rejects.
2. credit=20, product_sell=00, purchase → credit 10, change_req=1, change_amount=10; change_ack after 3 cycles → credit=0, change_req=0 next cycle.
3. credit=15, cancel → change_req=1, change_amount=15; coin_valid in REFUND → coin_reject pulse, change_amount still 15; ack → credit=0.
4. credit=45, coin 11 → coin_reject, credit stays 45; coin 10 → credit 50; coin_code 00 → coin_reject; credit=50 and accept_en=0 then coin 01 → coin_reject.
5. Same-cycle priority:
   - credit=12, cancel+purchase+coin in one cycle → refund 12, coin_reject=1, no deduction.
   - credit=8, product_sell=00, purchase → purchase_err pulse, credit 8.
   - credit=10, product_sell=00, purchase → credit 0, no change_req.
6. rst_n low mid-REFUND (change_amount=10) → change_req, credit, change_amount drop to 0 without a clock edge; after release, coin 10 → credit 5.
